// File: rtl/aes_rand_pkg.sv
// Shared types and default constants for the AES mask-randomness buffer.
package aes_rand_pkg;

  localparam int RAND_W_DEF = 256;
  localparam int DEPTH_DEF  = 4;

  // ST_ALARM is reachable only when the health check is compiled in.
  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_RUN,
    ST_ALARM
  } state_t;

endpackage

// File: rtl/aes_rand_fifo_mem.sv
// DEPTH x RAND_W register array: one synchronous write port, one combinational read port.
module aes_rand_fifo_mem
  import aes_rand_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [RAND_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [RAND_W-1:0]        rd_data
);

  logic [RAND_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the level counter
  // outside, so clearing wide storage would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aes_rand_buf.sv
// Prefetch buffer between the mask RNG and the masked S-box datapath.
// Optional RNG repeat-word health check: define AES_RAND_HEALTH_EN.
module aes_rand_buf
  import aes_rand_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WARMUP = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     rng_enable_o,
  input  logic [RAND_W-1:0]        rng_data_i,
  input  logic                     rng_valid_i,
  input  logic                     rd_req_i,
  output logic [RAND_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o,
  output logic                     alarm_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam state_t RST_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t            state, state_nx;
  logic [PW-1:0]     wr_ptr, rd_ptr, head_ptr;
  logic [LW-1:0]     level_nx;
  logic [CW-1:0]     warm_cnt;
  logic              skip_q;
  logic              arrive, flush, pop, push, drop, dup, health_fail;
  logic              en_nx, rd_valid_nx;
  logic [RAND_W-1:0] mem_rd_data;

`ifdef AES_RAND_HEALTH_EN
  logic [RAND_W-1:0] prev_word;
  logic              prev_vld;

  assign dup     = prev_vld && (rng_data_i == prev_word);
  assign alarm_o = (state == ST_ALARM);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_word <= '0;
      prev_vld  <= 1'b0;
    end else if (arrive && state != ST_ALARM) begin
      prev_word <= rng_data_i;
      prev_vld  <= 1'b1;
    end
  end
`else
  assign dup     = 1'b0;
  assign alarm_o = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path
  // through it leaves a variable unassigned and a latch inferred.
  always_comb begin
    arrive      = rng_valid_i && !skip_q;
    flush       = flush_i && (state != ST_ALARM);
    pop         = (state == ST_RUN) && rd_valid_o && rd_req_i && !flush;
    health_fail = (state == ST_RUN) && arrive && !flush && dup;
    push        = (state == ST_RUN) && arrive && !flush && !health_fail &&
                  ((level_o != LW'(DEPTH)) || pop);
    drop        = (state == ST_RUN) && arrive && !flush && !health_fail &&
                  (level_o == LW'(DEPTH)) && !pop;
    head_ptr    = pop ? rd_ptr + PW'(1) : rd_ptr;

    state_nx = state;
    case (state)
      ST_WARMUP: if (arrive && warm_cnt == CW'(WARMUP - 1)) state_nx = ST_RUN;
      ST_RUN:    if (health_fail) state_nx = ST_ALARM;
      default:   state_nx = state;
    endcase

    level_nx = flush ? '0 : level_o + LW'(push) - LW'(pop);

    // The current rng_enable_o is the word still in flight next cycle.
    en_nx = 1'b0;
    case (state_nx)
      ST_WARMUP: en_nx = 1'b1;
      ST_RUN:    en_nx = (level_nx + LW'(rng_enable_o)) < LW'(DEPTH);
      default:   en_nx = 1'b0;
    endcase
    rd_valid_nx = (state_nx == ST_RUN) && (level_nx != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= RST_STATE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_o      <= '0;
      warm_cnt     <= '0;
      skip_q       <= 1'b1;
      rng_enable_o <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
      drop_o       <= 1'b0;
    end else begin
      state        <= state_nx;
      level_o      <= level_nx;
      skip_q       <= flush;
      drop_o       <= drop;
      rng_enable_o <= en_nx;
      rd_valid_o   <= rd_valid_nx;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (state == ST_WARMUP && arrive) warm_cnt <= warm_cnt + CW'(1);
      // Bypass the array when the word being written becomes the new head.
      rd_data_o <= (push && wr_ptr == head_ptr) ? rng_data_i : mem_rd_data;
    end
  end

  aes_rand_fifo_mem #(
    .RAND_W (RAND_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (rng_data_i),
    .rd_addr (head_ptr),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_aes_rand_buf.sv
// Directed bench for aes_rand_buf: vector table for warm-up/fill, small FIFO model for streaming/flush.
module tb_aes_rand_buf;

  localparam int W     = 256;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rng_enable_o;
  logic [W-1:0] rng_data_i = '0;
  logic         rng_valid_i = 1'b0;
  logic         rd_req_i = 1'b0;
  logic [W-1:0] rd_data_o;
  logic         rd_valid_o;
  logic         flush_i = 1'b0;
  logic [2:0]   level_o;
  logic         drop_o;
  logic         alarm_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  aes_rand_buf #(.RAND_W(W), .DEPTH(DEPTH), .WARMUP(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rng_enable_o (rng_enable_o),
    .rng_data_i   (rng_data_i),
    .rng_valid_i  (rng_valid_i),
    .rd_req_i     (rd_req_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .flush_i      (flush_i),
    .level_o      (level_o),
    .drop_o       (drop_o),
    .alarm_o      (alarm_o)
  );

`ifdef AES_RAND_HEALTH_EN
  logic         z_resetn = 1'b0;
  logic         z_valid = 1'b0;
  logic         z_en, z_rv, z_drop, z_alarm;
  logic [W-1:0] z_rdata;
  logic [2:0]   z_level;

  aes_rand_buf #(.RAND_W(W), .DEPTH(DEPTH), .WARMUP(0)) dut_zero (
    .clk          (clk),
    .resetn       (z_resetn),
    .rng_enable_o (z_en),
    .rng_data_i   ('0),
    .rng_valid_i  (z_valid),
    .rd_req_i     (1'b0),
    .rd_data_o    (z_rdata),
    .rd_valid_o   (z_rv),
    .flush_i      (1'b0),
    .level_o      (z_level),
    .drop_o       (z_drop),
    .alarm_o      (z_alarm)
  );
`endif

  typedef struct {
    logic       rstn;
    logic       vld;
    logic [7:0] data;
    logic       rd;
    logic       fl;
    logic       en;
    logic       rv;
    logic [7:0] rdata;
    logic [2:0] lvl;
    logic       drop;
  } vec_t;

  vec_t         tbl [13];
  logic [W-1:0] q [$];
  logic         last_en = 1'b0;
  logic         skip_m = 1'b0;
  int           word_ctr = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One directed cycle: drive inputs, clock, compare registered outputs.
  task automatic apply(input vec_t v, input string tag);
    resetn      = v.rstn;
    rng_valid_i = v.vld;
    rng_data_i  = W'(v.data);
    rd_req_i    = v.rd;
    flush_i     = v.fl;
    tick();
    check({tag, ".en"},    W'(rng_enable_o), W'(v.en));
    check({tag, ".rv"},    W'(rd_valid_o),   W'(v.rv));
    check({tag, ".lvl"},   W'(level_o),      W'(v.lvl));
    check({tag, ".drop"},  W'(drop_o),       W'(v.drop));
    check({tag, ".alarm"}, W'(alarm_o),      W'(1'b0));
    if (v.rv) check({tag, ".data"}, rd_data_o, W'(v.rdata));
  endtask

  // One cycle against the FIFO model; the RNG answers every request one cycle later.
  task automatic mcycle(input logic rd, input logic fl, input string tag);
    logic         pop_m, arr_m, exp_drop;
    logic [W-1:0] word;
    word        = W'(32'h1000) + W'(word_ctr);
    resetn      = 1'b1;
    rng_valid_i = last_en;
    rng_data_i  = word;
    rd_req_i    = rd;
    flush_i     = fl;
    if (last_en) word_ctr++;
    pop_m   = rd && (q.size() > 0);
    arr_m   = last_en && !skip_m;
    last_en = rng_enable_o;
    tick();
    exp_drop = 1'b0;
    if (fl) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (arr_m) begin
        if (q.size() < DEPTH) q.push_back(word);
        else exp_drop = 1'b1;
      end
    end
    skip_m = fl;
    check({tag, ".lvl"},  W'(level_o),     W'(q.size()));
    check({tag, ".rv"},   W'(rd_valid_o),  W'(q.size() > 0));
    check({tag, ".drop"}, W'(drop_o),      W'(exp_drop));
    check({tag, ".en"},   W'(rng_enable_o), W'((q.size() + int'(last_en)) < DEPTH));
    if (q.size() > 0) check({tag, ".data"}, rd_data_o, q[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rstn vld data  rd fl | en rv rdata lvl drop
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd3, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd4, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd4, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd4, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd4, 1'b0};

    // Reset, warm-up discard, fill to full with backpressure, unsolicited word at full.
    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Streaming with rd_req_i held: contents 33,44,55,66 then fresh words, pointers wrap.
    q.push_back(W'(8'h33));
    q.push_back(W'(8'h44));
    q.push_back(W'(8'h55));
    q.push_back(W'(8'h66));
    last_en = 1'b0;
    for (int i = 0; i < 12; i++) mcycle(1'b1, 1'b0, "stream");

    // Stop reading until level 3 with a word in flight, then flush together with a pop.
    for (int i = 0; i < 8 && level_o != 3'd3; i++) mcycle(1'b0, 1'b0, "fill3");
    check("reach_l3", W'(level_o), W'(3'd3));
    mcycle(1'b1, 1'b1, "flush_a");
    check("flush_a_lvl0", W'(level_o), W'(0));
    for (int i = 0; i < 3; i++) mcycle(1'b0, 1'b0, "refill_a");

    // Flush while a request is out: the word arriving next cycle is dropped silently.
    check("flush_b_en", W'(rng_enable_o), W'(1'b1));
    mcycle(1'b0, 1'b1, "flush_b");
    mcycle(1'b0, 1'b0, "post_flush");
    check("post_flush_lvl", W'(level_o), W'(0));
    check("post_flush_drop", W'(drop_o), W'(1'b0));
    for (int i = 0; i < 8; i++) mcycle(1'b0, 1'b0, "refill_b");
    check("refill_full", W'(level_o), W'(3'd4));
    check("refill_en_low", W'(rng_enable_o), W'(1'b0));

    // Reset mid-operation: contents lost, first post-release word ignored, warm-up repeats.
    apply('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0}, "mid_rst");
    apply('{1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "rel");
    apply('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "rel_idle");
    apply('{1'b1, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "warm_c2");
    apply('{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "warm_c3");
    apply('{1'b1, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC4, 3'd1, 1'b0}, "first_c4");

`ifdef AES_RAND_HEALTH_EN
    // Repeated word in RUN raises a sticky alarm; only reset clears it.
    apply('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0}, "h_rst");
    apply('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "h_rel");
    apply('{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "h_w1");
    apply('{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0}, "h_w2");
    apply('{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd1, 1'b0}, "h_5a");
    resetn = 1'b1; rng_valid_i = 1'b1; rng_data_i = W'(8'h5A); rd_req_i = 1'b0; flush_i = 1'b0;
    tick();
    check("h_alarm", W'(alarm_o), W'(1'b1));
    for (int i = 0; i < 4; i++) begin
      rng_valid_i = 1'b1; rng_data_i = W'(8'h70 + i); rd_req_i = 1'b1; flush_i = i[0];
      tick();
      check("h_sticky_alarm", W'(alarm_o), W'(1'b1));
      check("h_sticky_en", W'(rng_enable_o), W'(1'b0));
      check("h_sticky_rv", W'(rd_valid_o), W'(1'b0));
    end
    resetn = 1'b0; rng_valid_i = 1'b0; rd_req_i = 1'b0; flush_i = 1'b0;
    tick();
    check("h_rst_alarm", W'(alarm_o), W'(1'b0));
    resetn = 1'b1;

    // All-zero source with no warm-up: first word accepted, second raises the alarm.
    z_resetn = 1'b0; z_valid = 1'b0;
    tick();
    z_resetn = 1'b1; z_valid = 1'b1;
    tick();
    check("z_ignored_lvl", W'(z_level), W'(0));
    tick();
    check("z_word1_alarm", W'(z_alarm), W'(1'b0));
    check("z_word1_lvl", W'(z_level), W'(1));
    check("z_word1_data", z_rdata, W'(0));
    tick();
    check("z_word2_alarm", W'(z_alarm), W'(1'b1));
    check("z_word2_en", W'(z_en), W'(1'b0));
    check("z_word2_rv", W'(z_rv), W'(1'b0));
    check("z_word2_drop", W'(z_drop), W'(1'b0));
    z_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
